// File: rtl/rf_write_arbiter_if.sv
// Write-request bundle for the register-file write arbiter: WB (fire-and-forget),
// MD and DBG (valid/ready). The master drives requests; the arbiter is the slave.
interface rf_write_arbiter_if #(
  parameter int width     = 32,
  parameter int AddrWidth = 5
);
  logic                 wb_we;
  logic [AddrWidth-1:0] wb_addr;
  logic [width-1:0]     wb_data;

  logic                 md_valid;
  logic [AddrWidth-1:0] md_addr;
  logic [width-1:0]     md_data;
  logic                 md_ready;

  logic                 dbg_valid;
  logic [AddrWidth-1:0] dbg_addr;
  logic [width-1:0]     dbg_data;
  logic                 dbg_ready;

  modport master (
    output wb_we, wb_addr, wb_data,
    output md_valid, md_addr, md_data,
    input  md_ready,
    output dbg_valid, dbg_addr, dbg_data,
    input  dbg_ready
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  md_valid, md_addr, md_data,
    output md_ready,
    input  dbg_valid, dbg_addr, dbg_data,
    output dbg_ready
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// Arbitrates WB, MD and DBG onto the single register-file write port, tracks
// destinations of in-flight MD operations, and forces a WB stall on MD/DBG starvation.
module rf_write_arbiter #(
  parameter int width        = 32,
  parameter int AddrWidth    = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  rf_write_arbiter_if.slave    wr,
  input  logic                 md_issue,
  input  logic [AddrWidth-1:0] md_issue_addr,
  input  logic [AddrWidth-1:0] chk_addr1,
  input  logic [AddrWidth-1:0] chk_addr2,
  output logic                 chk_hazard,
  output logic                 stall_wb,
  output logic                 RegWrite,
  output logic [AddrWidth-1:0] Write_register,
  output logic [width-1:0]     Write_data
);

  localparam int NREG  = 1 << AddrWidth;
  localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

  typedef enum logic       {RR_MD, RR_DBG} rr_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_MD, GNT_DBG} grant_e;

  grant_e               grant;
  rr_e                  rr_q, rr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 stall_wb_q, stall_wb_d;
  logic                 reg_write_q, reg_write_d;
  logic [AddrWidth-1:0] wr_reg_q, wr_reg_d;
  logic [width-1:0]     wr_data_q, wr_data_d;
  logic [NREG-1:0]      pending_q, pending_d;
  logic                 starve_inc;

  // WB has priority unless the starvation stall is active; MD/DBG ties go to rr_q.
  always_comb begin
    grant = GNT_NONE;
    if (!stall_wb_q && wr.wb_we)           grant = GNT_WB;
    else if (wr.md_valid && wr.dbg_valid)  grant = (rr_q == RR_MD) ? GNT_MD : GNT_DBG;
    else if (wr.md_valid)                  grant = GNT_MD;
    else if (wr.dbg_valid)                 grant = GNT_DBG;
  end

  // Ready is gated so no handshake can complete while the flops are held in reset.
  assign wr.md_ready  = reset && (grant == GNT_MD);
  assign wr.dbg_ready = reset && (grant == GNT_DBG);

  assign starve_inc = (wr.md_valid || wr.dbg_valid) &&
                      (grant != GNT_MD) && (grant != GNT_DBG);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    reg_write_d = 1'b0;
    wr_reg_d    = wr_reg_q;
    wr_data_d   = wr_data_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    stall_wb_d  = 1'b0;
    pending_d   = pending_q;

    unique case (grant)
      GNT_WB: begin
        wr_reg_d    = wr.wb_addr;
        wr_data_d   = wr.wb_data;
        reg_write_d = (wr.wb_addr != '0);
      end
      GNT_MD: begin
        wr_reg_d    = wr.md_addr;
        wr_data_d   = wr.md_data;
        reg_write_d = (wr.md_addr != '0);
        rr_d        = RR_DBG;
        cnt_d       = '0;
        pending_d[wr.md_addr] = 1'b0;
      end
      GNT_DBG: begin
        wr_reg_d    = wr.dbg_addr;
        wr_data_d   = wr.dbg_data;
        reg_write_d = (wr.dbg_addr != '0);
        rr_d        = RR_MD;
        cnt_d       = '0;
      end
      default: ;
    endcase

    if (starve_inc) begin
      if (cnt_q == CNT_LAST) begin
        stall_wb_d = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Issue is applied after the MD clear so a same-cycle set wins; r0 is never tracked.
    if (md_issue && (md_issue_addr != '0)) pending_d[md_issue_addr] = 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q        <= RR_MD;
      cnt_q       <= '0;
      stall_wb_q  <= 1'b0;
      reg_write_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      // NOTE: the scoreboard is reset because a stale pending bit would stall decode forever.
      pending_q   <= '0;
    end else begin
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      stall_wb_q  <= stall_wb_d;
      reg_write_q <= reg_write_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      pending_q   <= pending_d;
    end
  end

  assign chk_hazard     = pending_q[chk_addr1] | pending_q[chk_addr2];
  assign stall_wb       = stall_wb_q;
  assign RegWrite       = reg_write_q;
  assign Write_register = wr_reg_q;
  assign Write_data     = wr_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed-vector bench for rf_write_arbiter: reset, WB/MD/DBG arbitration,
// round-robin, starvation stall and the pending-destination scoreboard.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_issue;
  logic [4:0]  md_issue_addr, chk_addr1, chk_addr2;
  logic        chk_hazard, stall_wb, RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;

  int n_vec  = 0;
  int n_miss = 0;

  rf_write_arbiter_if #(.width(32), .AddrWidth(5)) wr_if ();

  rf_write_arbiter #(.width(32), .AddrWidth(5), .STARVE_LIMIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr             (wr_if),
    .md_issue       (md_issue),
    .md_issue_addr  (md_issue_addr),
    .chk_addr1      (chk_addr1),
    .chk_addr2      (chk_addr2),
    .chk_hazard     (chk_hazard),
    .stall_wb       (stall_wb),
    .RegWrite       (RegWrite),
    .Write_register (Write_register),
    .Write_data     (Write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_if.wb_we     = 1'b0; wr_if.wb_addr  = '0; wr_if.wb_data  = '0;
    wr_if.md_valid  = 1'b0; wr_if.md_addr  = '0; wr_if.md_data  = '0;
    wr_if.dbg_valid = 1'b0; wr_if.dbg_addr = '0; wr_if.dbg_data = '0;
    md_issue = 1'b0; md_issue_addr = '0;
  endtask

  task automatic check_write(input string tag, input logic we,
                             input logic [4:0] addr, input logic [31:0] data);
    check({tag, "_we"},   32'(RegWrite),       32'(we));
    check({tag, "_addr"}, 32'(Write_register), 32'(addr));
    check({tag, "_data"}, Write_data,          data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    chk_addr1 = '0; chk_addr2 = '0;
    reset = 1'b0;
    wr_if.md_valid = 1'b1; wr_if.md_addr = 5'd3; wr_if.md_data = 32'h0000_0033;
    repeat (2) tick();

    // Held in reset with an MD request pending.
    check("rst_md_ready", 32'(wr_if.md_ready), 32'd0);
    check("rst_stall",    32'(stall_wb),       32'd0);
    check("rst_hazard",   32'(chk_hazard),     32'd0);
    check_write("rst", 1'b0, 5'd0, 32'h0);

    // First MD grant after release lands one cycle later.
    reset = 1'b1;
    #1 check("rel_md_ready", 32'(wr_if.md_ready), 32'd1);
    tick();
    check_write("rel_md", 1'b1, 5'd3, 32'h0000_0033);

    // Lone WB write, then WB write to r0, then an idle cycle holding addr/data.
    idle();
    wr_if.wb_we = 1'b1; wr_if.wb_addr = 5'd5; wr_if.wb_data = 32'hA5A5_A5A5;
    tick();
    check_write("wb5", 1'b1, 5'd5, 32'hA5A5_A5A5);
    wr_if.wb_addr = 5'd0; wr_if.wb_data = 32'h0000_1234;
    tick();
    check_write("wb0", 1'b0, 5'd0, 32'h0000_1234);
    idle();
    tick();
    check_write("idle", 1'b0, 5'd0, 32'h0000_1234);

    // Both MD and DBG valid: rr points at DBG after the earlier MD grant (WB left it alone).
    wr_if.md_valid  = 1'b1; wr_if.md_addr  = 5'd7; wr_if.md_data  = 32'h0000_0077;
    wr_if.dbg_valid = 1'b1; wr_if.dbg_addr = 5'd8; wr_if.dbg_data = 32'h0000_0088;
    for (int i = 0; i < 4; i++) begin
      logic dbg_turn;
      dbg_turn = (i % 2 == 0);
      #1;
      check($sformatf("rr%0d_md_ready", i),  32'(wr_if.md_ready),  32'(!dbg_turn));
      check($sformatf("rr%0d_dbg_ready", i), 32'(wr_if.dbg_ready), 32'(dbg_turn));
      tick();
      check_write($sformatf("rr%0d", i), 1'b1, dbg_turn ? 5'd8 : 5'd7,
                  dbg_turn ? 32'h0000_0088 : 32'h0000_0077);
    end

    // Starvation: WB hogs the port while MD waits; stall on the fifth cycle.
    idle();
    wr_if.wb_we    = 1'b1; wr_if.wb_addr = 5'd1; wr_if.wb_data = 32'h0000_0011;
    wr_if.md_valid = 1'b1; wr_if.md_addr = 5'd4; wr_if.md_data = 32'h0000_0044;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("starve%0d_md_ready", i), 32'(wr_if.md_ready), 32'd0);
      tick();
      check($sformatf("starve%0d_stall", i), 32'(stall_wb), 32'(i == 3));
      check_write($sformatf("starve%0d", i), 1'b1, 5'd1, 32'h0000_0011);
    end
    #1 check("stall_md_ready", 32'(wr_if.md_ready), 32'd1);
    tick();
    check_write("stall_md", 1'b1, 5'd4, 32'h0000_0044);
    check("stall_clear", 32'(stall_wb), 32'd0);

    // Scoreboard: issue to r9 sets pending.
    idle();
    md_issue = 1'b1; md_issue_addr = 5'd9; chk_addr1 = 5'd9; chk_addr2 = 5'd0;
    #1 check("sb_pre", 32'(chk_hazard), 32'd0);
    tick();
    md_issue = 1'b0;
    #1 check("sb_set", 32'(chk_hazard), 32'd1);

    // DBG write to a pending register leaves it pending.
    wr_if.dbg_valid = 1'b1; wr_if.dbg_addr = 5'd9; wr_if.dbg_data = 32'h0000_0099;
    tick();
    idle();
    check_write("sb_dbg", 1'b1, 5'd9, 32'h0000_0099);
    check("sb_dbg_keep", 32'(chk_hazard), 32'd1);
    chk_addr1 = 5'd0; chk_addr2 = 5'd9;
    #1 check("sb_chk2", 32'(chk_hazard), 32'd1);

    // MD transfer to r9 clears it.
    wr_if.md_valid = 1'b1; wr_if.md_addr = 5'd9; wr_if.md_data = 32'h0000_0909;
    tick();
    idle();
    #1 check("sb_clear", 32'(chk_hazard), 32'd0);

    // Same-cycle issue and transfer of r9: set wins.
    wr_if.md_valid = 1'b1; wr_if.md_addr = 5'd9;
    md_issue = 1'b1; md_issue_addr = 5'd9;
    tick();
    idle();
    #1 check("sb_set_wins", 32'(chk_hazard), 32'd1);

    // Issue to r0 is never tracked.
    md_issue = 1'b1; md_issue_addr = 5'd0; chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    tick();
    idle();
    #1 check("sb_r0", 32'(chk_hazard), 32'd0);

    // Reset mid-run with a write just landed and r9 still pending.
    chk_addr1 = 5'd9;
    wr_if.md_valid = 1'b1; wr_if.md_addr = 5'd12; wr_if.md_data = 32'h0000_0C0C;
    tick();
    check_write("pre_rst", 1'b1, 5'd12, 32'h0000_0C0C);
    check("pre_rst_hazard", 32'(chk_hazard), 32'd1);
    wr_if.md_addr = 5'd13; wr_if.md_data = 32'h0000_0D0D;
    reset = 1'b0;
    #1;
    check("mid_rst_md_ready", 32'(wr_if.md_ready), 32'd0);
    check("mid_rst_hazard",   32'(chk_hazard),     32'd0);
    check_write("mid_rst", 1'b0, 5'd0, 32'h0);
    tick();
    reset = 1'b1;
    #1 check("post_rst_md_ready", 32'(wr_if.md_ready), 32'd1);
    tick();
    idle();
    check_write("post_rst", 1'b1, 5'd13, 32'h0000_0D0D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
